pipe_stage_skid: RTL and testbench

- Parametrised successor to the fixed MEM/WB-style stage register; drop-in between any two pipeline stages of the MIPS core.
- Adds a valid/ready handshake with a 2-entry skid buffer, so backpressure never needs a combinational ready path through the stage.
- Flush inserts a bubble by zeroing control; a saturating stall counter is included for performance debug.

---
 rtl/pipe_stage_skid.sv | 124 ++++++++++++
 tb/tb_pipe_stage_skid.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_skid.sv
// Pipeline stage register with valid/ready handshake and a 2-entry skid buffer.
// Flush or reset drops buffered entries and forces control to zero (bubble).
module pipe_stage_skid #(
   parameter int unsigned DATA_W              = 69,
   parameter int unsigned CTRL_W              = 2,
   parameter bit          CLEAR_DATA_ON_FLUSH = 1'b1,
   parameter int unsigned STALL_CNT_W         = 16
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   flush,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [CTRL_W-1:0]      in_ctrl,
   input  logic [DATA_W-1:0]      in_data,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [CTRL_W-1:0]      out_ctrl,
   output logic [DATA_W-1:0]      out_data,
   output logic [1:0]             occupancy,
   output logic [STALL_CNT_W-1:0] stall_cycles
);

   localparam logic [1:0] EMPTY = 2'd0;
   localparam logic [1:0] ONE   = 2'd1;
   localparam logic [1:0] FULL  = 2'd2;

   localparam logic [STALL_CNT_W-1:0] STALL_INC = {{(STALL_CNT_W-1){1'b0}}, 1'b1};

   logic [1:0]             state, state_n;
   logic                   ready_r;
   logic [CTRL_W-1:0]      out_ctrl_r, out_ctrl_n, skid_ctrl, skid_ctrl_n;
   logic [DATA_W-1:0]      out_data_r, out_data_n, skid_data, skid_data_n;
   logic [STALL_CNT_W-1:0] stall_r;
   logic                   accept, emit;

   assign accept = in_valid && ready_r;
   assign emit   = (state != EMPTY) && out_ready;

   always_comb begin
      state_n     = state;
      out_ctrl_n  = out_ctrl_r;
      out_data_n  = out_data_r;
      skid_ctrl_n = skid_ctrl;
      skid_data_n = skid_data;
      case (state)
         EMPTY: begin
            if (accept) begin
               out_ctrl_n = in_ctrl;
               out_data_n = in_data;
               state_n    = ONE;
            end
         end
         ONE: begin
            if (accept && emit) begin
               out_ctrl_n = in_ctrl;
               out_data_n = in_data;
            end else if (accept) begin
               skid_ctrl_n = in_ctrl;
               skid_data_n = in_data;
               state_n     = FULL;
            end else if (emit) begin
               // Draining to empty leaves a bubble: control cleared, payload kept.
               out_ctrl_n = '0;
               state_n    = EMPTY;
            end
         end
         FULL: begin
            if (emit) begin
               out_ctrl_n = skid_ctrl;
               out_data_n = skid_data;
               state_n    = ONE;
            end
         end
         default: begin
            out_ctrl_n = '0;
            state_n    = EMPTY;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset || flush) begin
         state      <= EMPTY;
         ready_r    <= 1'b1;
         out_ctrl_r <= '0;
         skid_ctrl  <= '0;
      end else begin
         state      <= state_n;
         ready_r    <= (state_n != FULL);
         out_ctrl_r <= out_ctrl_n;
         skid_ctrl  <= skid_ctrl_n;
      end
   end

   // Payload registers hold through reset/flush unless clearing is enabled.
   always_ff @(posedge clk) begin
      if (!reset || flush) begin
         if (CLEAR_DATA_ON_FLUSH) begin
            out_data_r <= '0;
            skid_data  <= '0;
         end
      end else begin
         out_data_r <= out_data_n;
         skid_data  <= skid_data_n;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         stall_r <= '0;
      end else if ((state != EMPTY) && !out_ready && (stall_r != '1)) begin
         stall_r <= stall_r + STALL_INC;
      end
   end

   assign in_ready     = ready_r;
   assign out_valid    = (state != EMPTY);
   assign out_ctrl     = out_ctrl_r;
   assign out_data     = out_data_r;
   assign occupancy    = state;
   assign stall_cycles = stall_r;

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Randomized and directed bench for pipe_stage_skid against a queue-based reference.
// Two instances share stimulus: default parameters, and no-clear data with a 3-bit stall counter.
module tb_pipe_stage_skid;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        flush = 1'b0;
   logic        in_valid = 1'b0;
   logic        out_ready = 1'b0;
   logic [1:0]  in_ctrl = '0;
   logic [68:0] in_data = '0;

   logic        in_ready0, out_valid0, in_ready1, out_valid1;
   logic [1:0]  out_ctrl0, out_ctrl1, occ0, occ1;
   logic [68:0] out_data0, out_data1;
   logic [15:0] stall0;
   logic [2:0]  stall1;

   int total = 0;
   int bad = 0;

   logic [70:0] q[$];
   int          m_stall0 = 0;
   int          m_stall1 = 0;

   always #5 clk = ~clk;

   pipe_stage_skid u_dut0 (
      .clk(clk), .reset(reset), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready0), .in_ctrl(in_ctrl), .in_data(in_data),
      .out_valid(out_valid0), .out_ready(out_ready), .out_ctrl(out_ctrl0), .out_data(out_data0),
      .occupancy(occ0), .stall_cycles(stall0)
   );

   pipe_stage_skid #(
      .DATA_W(69), .CTRL_W(2), .CLEAR_DATA_ON_FLUSH(1'b0), .STALL_CNT_W(3)
   ) u_dut1 (
      .clk(clk), .reset(reset), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready1), .in_ctrl(in_ctrl), .in_data(in_data),
      .out_valid(out_valid1), .out_ready(out_ready), .out_ctrl(out_ctrl1), .out_data(out_data1),
      .occupancy(occ1), .stall_cycles(stall1)
   );

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic check_all();
      logic [70:0] head;
      bit          v;
      v = (q.size() > 0);
      head = v ? q[0] : '0;
      check("occ0", occ0, q.size());
      check("occ1", occ1, q.size());
      check("valid0", out_valid0, v);
      check("valid1", out_valid1, v);
      check("ready0", in_ready0, q.size() < 2);
      check("ready1", in_ready1, q.size() < 2);
      check("ctrl0", out_ctrl0, head[70:69]);
      check("ctrl1", out_ctrl1, head[70:69]);
      if (v) begin
         check("data0", out_data0, head[68:0]);
         check("data1", out_data1, head[68:0]);
      end
      check("stall0", stall0, m_stall0);
      check("stall1", stall1, m_stall1);
   endtask

   // Apply inputs for one cycle, advance the reference at the edge, check at the next negedge.
   task automatic step(input bit r, input bit f, input bit v, input bit o,
                       input logic [1:0] c, input logic [68:0] d);
      int sz;
      bit acc, em;
      reset = r; flush = f; in_valid = v; out_ready = o; in_ctrl = c; in_data = d;
      @(posedge clk);
      sz  = q.size();
      acc = v && (sz < 2);
      em  = (sz > 0) && o;
      if (!r) begin
         q.delete();
         m_stall0 = 0;
         m_stall1 = 0;
      end else begin
         if (sz > 0 && !o) begin
            if (m_stall0 < 65535) m_stall0++;
            if (m_stall1 < 7) m_stall1++;
         end
         if (f) q.delete();
         else begin
            if (em) void'(q.pop_front());
            if (acc) q.push_back({c, d});
         end
      end
      @(negedge clk);
      check_all();
   endtask

   initial begin
      logic [68:0] rd;
      // Reset for two cycles.
      step(0, 0, 0, 0, 2'b00, '0);
      step(0, 0, 0, 0, 2'b00, '0);
      check("rst_data0", out_data0, 69'h0);
      step(1, 0, 0, 1, 2'b00, '0);

      // Streaming: one-cycle latency, occupancy stays 1.
      for (int i = 1; i <= 5; i++) begin
         step(1, 0, 1, 1, 2'b01, 69'(i));
         check("stream_data", out_data0, 69'(i));
         check("stream_occ", occ0, 2'd1);
      end
      step(1, 0, 0, 1, 2'b00, '0);

      // Backpressure fill, then drain in order.
      step(1, 0, 1, 0, 2'b10, 69'hA);
      step(1, 0, 1, 0, 2'b10, 69'hB);
      check("bp_full_ready", in_ready0, 1'b0);
      step(1, 0, 1, 0, 2'b10, 69'hC);
      check("bp_head", out_data0, 69'hA);
      step(1, 0, 1, 1, 2'b10, 69'hC);
      check("bp_second", out_data0, 69'hB);
      step(1, 0, 1, 1, 2'b10, 69'hC);
      check("bp_third", out_data0, 69'hC);
      step(1, 0, 0, 1, 2'b00, '0);

      // Flush while FULL, with an input offered on the same cycle.
      step(1, 0, 1, 0, 2'b11, 69'h11);
      step(1, 0, 1, 0, 2'b11, 69'h22);
      step(1, 1, 1, 0, 2'b11, 69'h33);
      check("flush_data0", out_data0, 69'h0);
      check("flush_occ", occ0, 2'd0);

      // Flush with data retention on the second instance.
      step(1, 0, 1, 0, 2'b01, 69'h55);
      step(1, 1, 0, 0, 2'b00, '0);
      check("hold_data1", out_data1, 69'h55);
      check("clear_data0", out_data0, 69'h0);

      // Stall counter saturation on the 3-bit instance.
      step(0, 0, 0, 0, 2'b00, '0);
      step(1, 0, 1, 0, 2'b01, 69'h77);
      for (int i = 0; i < 10; i++) step(1, 0, 0, 0, 2'b00, '0);
      check("sat_stall1", stall1, 3'd7);
      step(1, 1, 0, 0, 2'b00, '0);
      check("sat_after_flush", stall1, 3'd7);
      step(0, 0, 0, 0, 2'b00, '0);
      check("sat_after_reset", stall1, 3'd0);

      // Random traffic.
      for (int i = 0; i < 10000; i++) begin
         rd = {$urandom(), $urandom(), $urandom()};
         step(($urandom_range(0, 499) != 0),
              ($urandom_range(0, 63) == 0),
              $urandom_range(0, 1) == 1,
              $urandom_range(0, 9) < 6,
              2'($urandom_range(0, 3)), rd);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
